spi_flash_responder: RTL
========================

Name: spi_flash_responder

Overview:
- Synthesizable SPI mode-0 slave that emulates the serial PROM's identification and status interface.
- Answers READ IDENTIFICATION (0x9F) with a 3-byte JEDEC ID; answers nothing else.
- Sits on the board SPI bus opposite the existing RDID initiator. Used for loopback bring-up and for regression without a real PROM.
- Runs entirely in the divided system clock domain and oversamples the bus.

Parameters:
- MANUF_ID, 8'h20, first RDID response byte.
- MEM_TYPE, 8'h20, second RDID response byte.
- MEM_CAP, 8'h15, third RDID response byte.
- SYNC_STAGES, 2, synchronizer depth on SPICLK/SPIMOSI/cs_prom_n (≥2).

Ports:
- clk  in  1  system clock; must be ≥8× SPICLK frequency.
- reset_n  in  1  synchronous, active-low reset.
- SPICLK  in  1  SPI serial clock from initiator; idles low.
- SPIMOSI  in  1  serial data from initiator.
- cs_prom_n  in  1  active-low chip select.
- status  in  8  status register value; used only with SPI_RDSR_EN.
- SPIMISO  out  1  serial data to initiator.
- miso_oe  out  1  high while this block drives SPIMISO.
- cmd_byte  out  8  last complete command byte received.
- cmd_valid  out  1  one-cycle pulse when cmd_byte updates.
- busy  out  1  high whenever chip select is asserted (synchronized).

Behaviour:
- Reset values: SPIMISO=0, miso_oe=0, cmd_byte=8'h00, cmd_valid=0, busy=0, state=IDLE, bit counter=0, byte counter=0.
- All three bus inputs pass through SYNC_STAGES flops. A further register on SPICLK provides edge detect: rise = cur & ~prev, fall = ~cur & prev.
- Chip-select deassertion (synchronized cs_n=1) forces IDLE and miso_oe=0 in the same cycle it is seen. This holds from any state and overrides any coincident SPICLK edge.
- IDLE:
  - Synchronized cs_n=0 → CMD; clear bit and byte counters; busy=1.
- CMD:
  - On each rise, shift synchronized MOSI into a shift register MSB-first; bit counter +1.
  - On the 8th rise: latch cmd_byte, pulse cmd_valid for exactly one clk, reset bit counter.
  - If cmd_byte=0x9F → RESP: load MANUF_ID into the tx shifter; byte counter=0.
  - Any other value → IGNORE.
- RESP:
  - On each fall, drive SPIMISO = tx[7], shift tx left, set miso_oe=1.
  - The first fall after the command drives MANUF_ID bit 7.
  - After 8 falls, byte counter +1 and reload the shifter: byte 1 = MEM_TYPE, byte 2 = MEM_CAP, byte ≥3 = 8'h00.
  - Byte counter saturates at 3. No wrap.
- IGNORE:
  - SPIMISO=0, miso_oe=0. Rises are counted but discarded.
  - Exit only via chip-select deassertion.
- Latency: SPIMISO changes SYNC_STAGES+1 clk after the SPICLK falling pin edge. At ≥8× oversampling this is valid before the initiator's next rising edge.
- Rise and fall in the same clk are impossible by construction. If both are seen, rise takes priority.
- reset_n low mid-transfer returns the block to reset values on the next clk. A transfer in progress must then restart with cs_n high→low.
- A cs_n glitch shorter than SYNC_STAGES clk may be missed. This is accepted behaviour.

Optional Feature:
- Macro: SPI_RDSR_EN.
- Defined: command 0x05 → RESP_SR state. The status byte is sampled once at the 8th command rise and shifted out on falls, MSB first. The sampled value repeats continuously until cs_n deasserts.
- Not defined: 0x05 goes to IGNORE, and the status port is unused.

Decomposition:
- Shared package spi_flash_pkg:
  - Command opcodes CMD_RDID=8'h9F and CMD_RDSR=8'h05.
  - State enum IDLE/CMD/RESP/RESP_SR/IGNORE.
  - Default ID byte constants.
- Sub-module: the existing sync block, instantiated once per bus input (three instances). No other sub-modules.

Test Plan:
- RDID: cs low, send 0x9F, clock 24 more bits.
  - Required: MISO bytes 0x20, 0x20, 0x15.
  - Required: cmd_valid pulses once with cmd_byte=0x9F; miso_oe=1 from the first response bit.
- Over-read: after 0x9F, clock 40 bits.
  - Required: bytes 0x20, 0x20, 0x15, 0x00, 0x00; byte counter holds at 3.
- Unknown command: send 0xAB, then clock 16 bits.
  - Required: miso_oe=0 and SPIMISO=0 throughout; cmd_byte=0xAB.
- Abort: raise cs_n after 4 bits of the response's first byte, then lower it and send 0x9F again.
  - Required: IDLE within SYNC_STAGES+1 clk of cs_n rising, miso_oe=0, and a fresh response starting at 0x20.
- Reset: assert reset_n=0 for 1 clk mid-response.
  - Required: all outputs at reset values the next cycle; a following transaction returns 0x20, 0x20, 0x15.
- With SPI_RDSR_EN: status=8'hA5, send 0x05, clock 16 bits.
  - Required: 0xA5, 0xA5.
  - Without the macro the same stimulus gives miso_oe=0.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM states and default JEDEC ID bytes for the SPI PROM responder.
package spi_flash_pkg;

  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  localparam logic [7:0] DEF_MANUF_ID = 8'h20;
  localparam logic [7:0] DEF_MEM_TYPE = 8'h20;
  localparam logic [7:0] DEF_MEM_CAP  = 8'h15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    RESP    = 3'd2,
    RESP_SR = 3'd3,
    IGNORE  = 3'd4
  } state_t;

  // Selects the RDID response byte for a given byte index; past the ID it reads zero.
  function automatic logic [7:0] id_byte(input logic [1:0] idx,
                                         input logic [7:0] manuf,
                                         input logic [7:0] mem_type,
                                         input logic [7:0] mem_cap);
    case (idx)
      2'd0:    return manuf;
      2'd1:    return mem_type;
      2'd2:    return mem_cap;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Multi-flop synchronizer for one asynchronous SPI bus input.
module spi_flash_responder_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the pin value through the flop chain.
  always_ff @(posedge clk) begin
    if (!reset_n) chain <= {STAGES{RESET_VAL}};
    else          chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 slave emulating the serial PROM RDID (0x9F) response.
// Optional RDSR (0x05) status readout is enabled by defining SPI_RDSR_EN.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter logic [7:0]  MANUF_ID    = DEF_MANUF_ID,
  parameter logic [7:0]  MEM_TYPE    = DEF_MEM_TYPE,
  parameter logic [7:0]  MEM_CAP     = DEF_MEM_CAP,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       SPICLK,
  input  logic       SPIMOSI,
  input  logic       cs_prom_n,
  input  logic [7:0] status,
  output logic       SPIMISO,
  output logic       miso_oe,
  output logic [7:0] cmd_byte,
  output logic       cmd_valid,
  output logic       busy
);

  logic       sclk_s, mosi_s, cs_n_s, sclk_prev;
  logic       sclk_rise, sclk_fall;
  state_t     state;
  logic [2:0] bit_cnt;
  logic [1:0] byte_cnt, byte_next;
  logic [7:0] rx_shift, rx_next, tx_shift;

`ifdef SPI_RDSR_EN
  logic [7:0] sr_val;
`else
  logic unused_status;
  assign unused_status = ^status;
`endif

  spi_flash_responder_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .d(SPICLK), .q(sclk_s));
  spi_flash_responder_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .d(SPIMOSI), .q(mosi_s));
  spi_flash_responder_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset_n(reset_n), .d(cs_prom_n), .q(cs_n_s));

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign rx_next   = {rx_shift[6:0], mosi_s};
  assign byte_next = (byte_cnt == 2'd3) ? 2'd3 : byte_cnt + 2'd1;

  // Protocol FSM: command capture on rises, response shifting on falls, cs_n release wins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      sclk_prev <= 1'b0;
      bit_cnt   <= 3'd0;
      byte_cnt  <= 2'd0;
      rx_shift  <= 8'h00;
      tx_shift  <= 8'h00;
      SPIMISO   <= 1'b0;
      miso_oe   <= 1'b0;
      cmd_byte  <= 8'h00;
      cmd_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SPI_RDSR_EN
      sr_val    <= 8'h00;
`endif
    end else begin
      sclk_prev <= sclk_s;
      cmd_valid <= 1'b0;
      if (cs_n_s) begin
        state   <= IDLE;
        miso_oe <= 1'b0;
        SPIMISO <= 1'b0;
        busy    <= 1'b0;
      end else begin
        busy <= 1'b1;
        case (state)
          IDLE: begin
            state    <= CMD;
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
          end
          CMD: begin
            if (sclk_rise) begin
              rx_shift <= rx_next;
              if (bit_cnt == 3'd7) begin
                bit_cnt   <= 3'd0;
                cmd_byte  <= rx_next;
                cmd_valid <= 1'b1;
                if (rx_next == CMD_RDID) begin
                  state    <= RESP;
                  tx_shift <= MANUF_ID;
                  byte_cnt <= 2'd0;
                end
`ifdef SPI_RDSR_EN
                else if (rx_next == CMD_RDSR) begin
                  state    <= RESP_SR;
                  sr_val   <= status;
                  tx_shift <= status;
                end
`endif
                else begin
                  state <= IGNORE;
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          RESP: begin
            if (sclk_fall) begin
              SPIMISO <= tx_shift[7];
              miso_oe <= 1'b1;
              if (bit_cnt == 3'd7) begin
                bit_cnt  <= 3'd0;
                byte_cnt <= byte_next;
                tx_shift <= id_byte(byte_next, MANUF_ID, MEM_TYPE, MEM_CAP);
              end else begin
                bit_cnt  <= bit_cnt + 3'd1;
                tx_shift <= {tx_shift[6:0], 1'b0};
              end
            end
          end
`ifdef SPI_RDSR_EN
          RESP_SR: begin
            if (sclk_fall) begin
              SPIMISO <= tx_shift[7];
              miso_oe <= 1'b1;
              if (bit_cnt == 3'd7) begin
                bit_cnt  <= 3'd0;
                tx_shift <= sr_val;
              end else begin
                bit_cnt  <= bit_cnt + 3'd1;
                tx_shift <= {tx_shift[6:0], 1'b0};
              end
            end
          end
`endif
          IGNORE: begin
            SPIMISO <= 1'b0;
            miso_oe <= 1'b0;
            if (sclk_rise) bit_cnt <= bit_cnt + 3'd1;
          end
          default: begin
            state   <= IGNORE;
            SPIMISO <= 1'b0;
            miso_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
